// File: rtl/gpio_int_ctrl_if.sv
// rtl/gpio_int_ctrl_if.sv - register port bundle between bus decoder and gpio_int_ctrl
interface gpio_int_ctrl_if #(
    parameter int NPORT = 16
);
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       addr;
    logic [NPORT-1:0] wdata;
    logic [NPORT-1:0] rdata;
    logic             rvalid;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/gpio_int_ctrl.sv
// rtl/gpio_int_ctrl.sv - GPIO input synchroniser, level/edge detector and interrupt controller
module gpio_int_ctrl #(
    parameter int NPORT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] portin,
    gpio_int_ctrl_if.slave   bus,
    output logic [NPORT-1:0] gpioint,
    output logic             combint
);
    localparam logic [2:0] ADDR_DATA_IN    = 3'd0;
    localparam logic [2:0] ADDR_INT_EN     = 3'd1;
    localparam logic [2:0] ADDR_INT_TYPE   = 3'd2;
    localparam logic [2:0] ADDR_INT_POL    = 3'd3;
    localparam logic [2:0] ADDR_INT_STATUS = 3'd4;

    logic [NPORT-1:0] s1_q, s1_d;
    logic [NPORT-1:0] s2_q, s2_d;
    logic [NPORT-1:0] s3_q, s3_d;
    logic [NPORT-1:0] int_en_q, int_en_d;
    logic [NPORT-1:0] int_type_q, int_type_d;
    logic [NPORT-1:0] int_pol_q, int_pol_d;
    logic [NPORT-1:0] status_q, status_d;
    logic [NPORT-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic [NPORT-1:0] rise;
    logic [NPORT-1:0] fall;
    logic [NPORT-1:0] edge_hit;
    logic [NPORT-1:0] level_hit;
    logic [NPORT-1:0] w1c;

    always_comb begin
        s1_d       = portin;
        s2_d       = s1_q;
        s3_d       = s2_q;
        int_en_d   = int_en_q;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
        w1c        = '0;

        rise      = s2_q & ~s3_q;
        fall      = ~s2_q & s3_q;
        edge_hit  = (int_pol_q & rise) | (~int_pol_q & fall);
        level_hit = ~(s2_q ^ int_pol_q);

        if (bus.wr_en) begin
            case (bus.addr)
                ADDR_INT_EN:     int_en_d   = bus.wdata;
                ADDR_INT_TYPE:   int_type_d = bus.wdata;
                ADDR_INT_POL:    int_pol_d  = bus.wdata;
                ADDR_INT_STATUS: w1c        = bus.wdata;
                default:         w1c        = '0;
            endcase
        end

        // Edge bits are sticky with set winning over clear; level bits simply follow the pin.
        status_d = (int_type_q & ((status_q & ~w1c) | edge_hit))
                 | (~int_type_q & level_hit);

        // Reads see the register values from before this cycle's write or status update.
        rvalid_d = bus.rd_en;
        rdata_d  = rdata_q;
        if (bus.rd_en) begin
            case (bus.addr)
                ADDR_DATA_IN:    rdata_d = s2_q;
                ADDR_INT_EN:     rdata_d = int_en_q;
                ADDR_INT_TYPE:   rdata_d = int_type_q;
                ADDR_INT_POL:    rdata_d = int_pol_q;
                ADDR_INT_STATUS: rdata_d = status_q;
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            int_en_q   <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            int_en_q   <= int_en_d;
            int_type_q <= int_type_d;
            int_pol_q  <= int_pol_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign gpioint    = status_q & int_en_q;
    assign combint    = |gpioint;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_gpio_int_ctrl.sv
// tb/tb_gpio_int_ctrl.sv - scoreboard bench for gpio_int_ctrl with behavioural reference model
module tb_gpio_int_ctrl;
    localparam int NPORT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NPORT-1:0] portin;
    logic [NPORT-1:0] gpioint;
    logic             combint;

    gpio_int_ctrl_if #(.NPORT(NPORT)) bus ();

    gpio_int_ctrl #(.NPORT(NPORT)) dut (
        .clk     (clk),
        .rst     (rst),
        .portin  (portin),
        .bus     (bus),
        .gpioint (gpioint),
        .combint (combint)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit running = 1'b0;

    // Reference model: pin_seen holds pin values captured at past edges, newest first.
    // Logic reacts to the pin as it was two edges ago (two synchroniser stages).
    logic [NPORT-1:0] pin_seen[$];
    logic [NPORT-1:0] m_en, m_type, m_pol, m_status;
    logic [NPORT-1:0] exp_rd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        pin_seen.delete();
        repeat (3) pin_seen.push_back('0);
        m_en     = '0;
        m_type   = '0;
        m_pol    = '0;
        m_status = '0;
        exp_rd.delete();
    endtask

    // One clock: predict from the inputs presented now, then commit right after the edge.
    task automatic tick();
        logic [NPORT-1:0] now_v, before_v, n_status, n_en, n_type, n_pol, rd_val, pins;
        logic             do_rd, do_rst, hit, cleared;
        now_v    = pin_seen[1];
        before_v = pin_seen[2];
        n_en     = m_en;
        n_type   = m_type;
        n_pol    = m_pol;
        for (int i = 0; i < NPORT; i++) begin
            if (m_type[i]) begin
                hit     = m_pol[i] ? (now_v[i] && !before_v[i]) : (!now_v[i] && before_v[i]);
                cleared = bus.wr_en && (bus.addr == 3'd4) && bus.wdata[i];
                n_status[i] = hit ? 1'b1 : (cleared ? 1'b0 : m_status[i]);
            end else begin
                n_status[i] = (now_v[i] == m_pol[i]);
            end
        end
        if (bus.wr_en) begin
            case (int'(bus.addr))
                1: n_en   = bus.wdata;
                2: n_type = bus.wdata;
                3: n_pol  = bus.wdata;
                default: ;
            endcase
        end
        case (int'(bus.addr))
            0: rd_val = now_v;
            1: rd_val = m_en;
            2: rd_val = m_type;
            3: rd_val = m_pol;
            4: rd_val = m_status;
            default: rd_val = '0;
        endcase
        do_rd  = bus.rd_en;
        do_rst = rst;
        pins   = portin;
        @(posedge clk);
        if (do_rst) begin
            model_clear();
        end else begin
            pin_seen.push_front(pins);
            void'(pin_seen.pop_back());
            m_en     = n_en;
            m_type   = n_type;
            m_pol    = n_pol;
            m_status = n_status;
            if (do_rd) exp_rd.push_back(rd_val);
        end
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [NPORT-1:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
    endtask

    task automatic rd(input logic [2:0] a);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        tick();
    endtask

    // Monitor: interrupt lines every cycle, read data whenever rvalid is presented.
    always @(negedge clk) begin
        if (running) begin
            check("gpioint", 32'(gpioint), 32'(m_status & m_en));
            check("combint", 32'(combint), 32'(|(m_status & m_en)));
            if (bus.rvalid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    check("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
                end else begin
                    check("rdata", 32'(bus.rdata), 32'(exp_rd.pop_front()));
                end
            end else if (exp_rd.size() != 0) begin
                check("rvalid_missing", 32'(bus.rvalid), 32'd1);
                void'(exp_rd.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        portin    = 16'hFFFF;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        model_clear();

        // Reset defaults
        tick();
        running = 1'b1;
        idle(4);
        check("reset_gpioint", 32'(gpioint), 32'd0);
        check("reset_combint", 32'(combint), 32'd0);
        check("reset_rvalid", 32'(bus.rvalid), 32'd0);
        rst = 1'b0;
        rd(3'd1);
        rd(3'd2);
        rd(3'd3);
        rd(3'd4);
        rd(3'd0);
        idle(1);

        // Rising-edge sticky and W1C on bit 0
        portin = 16'h0000;
        idle(4);
        wr(3'd1, 16'h0001);
        wr(3'd2, 16'h0001);
        wr(3'd3, 16'h0001);
        wr(3'd4, 16'hFFFF);
        portin = 16'h0001;
        idle(2);
        check("rise_latency_early", 32'(gpioint), 32'h0);
        idle(1);
        check("rise_gpioint", 32'(gpioint), 32'h0001);
        check("rise_combint", 32'(combint), 32'd1);
        portin = 16'h0000;
        idle(4);
        check("rise_held", 32'(gpioint), 32'h0001);
        rd(3'd4);
        wr(3'd4, 16'h0001);
        check("rise_w1c", 32'(gpioint), 32'h0);

        // Level-low tracking on bit 15
        portin = 16'hFFFF;
        idle(4);
        wr(3'd1, 16'h8000);
        wr(3'd2, 16'h0000);
        wr(3'd3, 16'h0000);
        check("level_idle", 32'(gpioint), 32'h0);
        portin = 16'h7FFF;
        idle(3);
        check("level_low", 32'(gpioint), 32'h8000);
        wr(3'd4, 16'h8000);
        check("level_w1c_ignored", 32'(gpioint), 32'h8000);
        portin = 16'hFFFF;
        idle(2);
        check("level_release_early", 32'(gpioint), 32'h8000);
        idle(1);
        check("level_release", 32'(gpioint), 32'h0);

        // Set beats clear on bit 3 falling edge
        wr(3'd1, 16'h0008);
        wr(3'd2, 16'h0008);
        wr(3'd3, 16'h0000);
        idle(3);
        wr(3'd4, 16'hFFFF);
        portin = 16'hFFF7;
        idle(2);
        wr(3'd4, 16'h0008);
        check("set_beats_clear", 32'(gpioint), 32'h0008);
        rd(3'd4);
        wr(3'd4, 16'h0008);
        check("clear_after_set", 32'(gpioint), 32'h0);

        // Masking: all edge, EN off, then partial enable
        wr(3'd1, 16'h0000);
        wr(3'd2, 16'hFFFF);
        wr(3'd3, 16'hFFFF);
        portin = 16'h0000;
        idle(4);
        wr(3'd4, 16'hFFFF);
        portin = 16'h00FF;
        idle(4);
        check("mask_gpioint", 32'(gpioint), 32'h0);
        rd(3'd4);
        wr(3'd1, 16'h000F);
        check("mask_enable", 32'(gpioint), 32'h000F);
        check("mask_combint", 32'(combint), 32'd1);

        // Reset mid-operation with a read in flight
        bus.rd_en = 1'b1;
        bus.addr  = 3'd4;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        check("midrst_gpioint", 32'(gpioint), 32'h0);
        rd(3'd4);
        rd(3'd1);

        // Randomised traffic against the reference model
        for (int n = 0; n < 4000; n++) begin
            int op;
            if ($urandom_range(3) == 0) portin = 16'($urandom);
            op = int'($urandom_range(9));
            if (op < 3) begin
                bus.wr_en = 1'b1;
                bus.addr  = 3'($urandom_range(7));
                bus.wdata = 16'($urandom);
            end
            if (op >= 2 && op < 6) begin
                bus.rd_en = 1'b1;
                if (op != 2) bus.addr = 3'($urandom_range(7));
            end
            rst = ($urandom_range(499) == 0);
            tick();
            rst = 1'b0;
        end

        idle(3);
        check("scoreboard_drained", 32'(exp_rd.size()), 32'd0);
        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
